// File: rtl/opl3_pkg.sv
// Shared widths, slot bundle and MULT lookup for the OPL3 operator phase path.
package opl3_pkg;
    localparam int BANK_NUM_WIDTH    = 1;
    localparam int OP_NUM_WIDTH      = 5;
    localparam int PHASE_ACC_WIDTH   = 19;
    localparam int PHASE_FINAL_WIDTH = 10;
    localparam int VIB_POS_WIDTH     = 3;
    localparam int NUM_OPERATORS     = 36;
    localparam int OPS_PER_BANK      = 18;
    localparam int TIMER_WIDTH       = 10;
    localparam int ADDR_WIDTH        = 6;

    typedef logic [ADDR_WIDTH-1:0]      op_addr_t;
    typedef logic [PHASE_ACC_WIDTH-1:0] acc_t;

    typedef struct packed {
        logic       en;
        logic       ok;
        logic       tick;
        op_addr_t   addr;
        logic [9:0] fnum;
        logic [2:0] block;
        logic [3:0] mult;
        logic       vib;
        logic       dvb;
        logic       kon;
    } slot_t;

    function automatic logic [4:0] mult2(input logic [3:0] code);
        logic [4:0] m;
        unique case (code)
            4'd0:  m = 5'd1;
            4'd1:  m = 5'd2;
            4'd2:  m = 5'd4;
            4'd3:  m = 5'd6;
            4'd4:  m = 5'd8;
            4'd5:  m = 5'd10;
            4'd6:  m = 5'd12;
            4'd7:  m = 5'd14;
            4'd8:  m = 5'd16;
            4'd9:  m = 5'd18;
            4'd10: m = 5'd20;
            4'd11: m = 5'd20;
            4'd12: m = 5'd24;
            4'd13: m = 5'd24;
            4'd14: m = 5'd30;
            4'd15: m = 5'd30;
        endcase
        return m;
    endfunction

    function automatic op_addr_t op_addr(
        input logic [BANK_NUM_WIDTH-1:0] bank,
        input logic [OP_NUM_WIDTH-1:0]   op
    );
        return op_addr_t'(bank) * op_addr_t'(OPS_PER_BANK) + op_addr_t'(op);
    endfunction
endpackage

// File: rtl/phase_acc_ram.sv
// Accumulator storage: 36 x 19 simple dual-port, registered read, no reset.
module phase_acc_ram
    import opl3_pkg::*;
(
    input  logic                       clk,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [PHASE_ACC_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0]      raddr,
    output logic [PHASE_ACC_WIDTH-1:0] rdata
);
    acc_t mem [NUM_OPERATORS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/phase_acc.sv
// Per-operator phase accumulator with vibrato, key-on clear and
// same-address write-back forwarding; phase appears two cycles after p0.
module phase_acc
    import opl3_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_clk_en,
    input  logic [BANK_NUM_WIDTH-1:0]    bank_num,
    input  logic [OP_NUM_WIDTH-1:0]      op_num,
    input  logic [9:0]                   fnum,
    input  logic [2:0]                   block,
    input  logic [3:0]                   mult,
    input  logic                         vib,
    input  logic                         dvb,
    input  logic                         key_on_pulse,
    output logic [PHASE_FINAL_WIDTH-1:0] phase_p2
);
    slot_t                     s0, s1;
    logic [TIMER_WIDTH-1:0]    timer;
    logic [VIB_POS_WIDTH-1:0]  vib_pos;
    logic [NUM_OPERATORS-1:0]  valid;
    logic                      fwd_hit;
    acc_t                      fwd_data, ram_q;
    logic [2:0]                vib_rng;
    logic [9:0]                vib_off, fnum_eff;
    logic [16:0]               fnum_sh;
    logic [20:0]               prod;
    acc_t                      inc, old_acc, base, new_acc;
    logic                      wr_en;

    always_comb begin
        s0       = '0;
        s0.en    = sample_clk_en;
        s0.ok    = op_num <= OP_NUM_WIDTH'(OPS_PER_BANK - 1);
        s0.tick  = (bank_num == '0) && (op_num == '0);
        s0.addr  = s0.ok ? op_addr(bank_num, op_num) : '0;
        s0.fnum  = fnum;
        s0.block = block;
        s0.mult  = mult;
        s0.vib   = vib;
        s0.dvb   = dvb;
        s0.kon   = key_on_pulse;
    end

    always_comb begin
        vib_rng = s1.fnum[9:7];
        if (vib_pos[0]) vib_rng = vib_rng >> 1;
        if (!s1.dvb) vib_rng = vib_rng >> 1;
        vib_off = {7'd0, vib_rng};
        if (vib_pos[2]) vib_off = -vib_off;
        if (!s1.vib || vib_pos[1:0] == 2'd0) vib_off = '0;
        fnum_eff = s1.fnum + vib_off;
        fnum_sh  = {7'd0, fnum_eff} << s1.block;
        prod     = 21'(fnum_sh >> 1) * 21'(mult2(s1.mult));
        inc      = acc_t'(prod >> 1);

        wr_en   = s1.en && s1.ok;
        old_acc = '0;
        // a write-back landing on the same edge as the RAM read is forwarded
        if (s1.ok) old_acc = fwd_hit ? fwd_data : (valid[s1.addr] ? ram_q : '0);
        base    = (wr_en && s1.kon) ? '0 : old_acc;
        new_acc = base + inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= '0;
            phase_p2 <= '0;
            valid    <= '0;
            timer    <= '0;
            vib_pos  <= '0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            s1       <= s0;
            phase_p2 <= base[PHASE_ACC_WIDTH-1 -: PHASE_FINAL_WIDTH];
            fwd_hit  <= wr_en && s0.ok && (s0.addr == s1.addr);
            fwd_data <= new_acc;
            if (wr_en) valid[s1.addr] <= 1'b1;
            if (s1.en && s1.tick) begin
                timer <= timer + 1'b1;
                if (timer == '1) vib_pos <= vib_pos + 1'b1;
            end
        end
    end

    phase_acc_ram u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (s1.addr),
        .wdata (new_acc),
        .raddr (s0.addr),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_phase_acc.sv
// Random and directed slot stream checked against an arithmetic reference model.
module tb_phase_acc;
    logic       clk = 1'b0;
    logic       reset;
    logic       sample_clk_en;
    logic [0:0] bank_num;
    logic [4:0] op_num;
    logic [9:0] fnum;
    logic [2:0] block;
    logic [3:0] mult;
    logic       vib;
    logic       dvb;
    logic       key_on_pulse;
    logic [9:0] phase_p2;

    int    total = 0;
    int    bad = 0;
    int    m_acc [36];
    bit    m_val [36];
    int    m_cnt = 0;
    int    m2tab [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 20, 24, 24, 30, 30};
    bit    prev_chk = 0;
    int    prev_exp = 0;
    string prev_tag = "";

    phase_acc dut (
        .clk           (clk),
        .reset         (reset),
        .sample_clk_en (sample_clk_en),
        .bank_num      (bank_num),
        .op_num        (op_num),
        .fnum          (fnum),
        .block         (block),
        .mult          (mult),
        .vib           (vib),
        .dvb           (dvb),
        .key_on_pulse  (key_on_pulse),
        .phase_p2      (phase_p2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_inc(int fn, int blk, int ml, bit vb, bit dv, int vp);
        int off, fe;
        off = 0;
        if (vb && (vp % 4) != 0) begin
            off = fn / 128;
            if (vp % 2 == 1) off = off / 2;
            if (!dv) off = off / 2;
            if (vp >= 4) off = -off;
        end
        fe = (fn + off + 1024) % 1024;
        return ((fe * (2 ** blk) / 2) * m2tab[ml] / 2) % 524288;
    endfunction

    task automatic issue(input bit en, input int bank, input int op, input int fn,
                         input int blk, input int ml, input bit vb, input bit dv,
                         input bit kon, input bit chk, input string tag);
        int a, base, exp_v;
        bit c;
        sample_clk_en = en;
        bank_num      = 1'(bank);
        op_num        = 5'(op);
        fnum          = 10'(fn);
        block         = 3'(blk);
        mult          = 4'(ml);
        vib           = vb;
        dvb           = dv;
        key_on_pulse  = kon;
        c = 0;
        exp_v = 0;
        if (op <= 17) begin
            a = bank * 18 + op;
            base = m_val[a] ? m_acc[a] : 0;
            if (en) begin
                if (kon) base = 0;
                m_acc[a] = (base + ref_inc(fn, blk, ml, vb, dv, (m_cnt / 1024) % 8)) % 524288;
                m_val[a] = 1;
                if (a == 0) m_cnt = (m_cnt + 1) % 8192;
            end
            exp_v = base / 512;
            c = chk;
        end
        @(posedge clk);
        #1;
        if (prev_chk) check(prev_tag, phase_p2, 10'(prev_exp));
        prev_chk = c;
        prev_exp = exp_v;
        prev_tag = tag;
    endtask

    initial begin
        int r, op, bank;
        reset = 1'b1;
        sample_clk_en = 0; bank_num = 0; op_num = 0; fnum = 0; block = 0;
        mult = 0; vib = 0; dvb = 0; key_on_pulse = 0;
        foreach (m_val[i]) m_val[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_phase", phase_p2, 10'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) issue(1, 0, 0, 'h200, 4, 1, 0, 1, 0, 1, "op0_mult1");
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 1, 'h200, 4, 0, 0, 1, 0, 1, "op1_mult0");
            issue(1, 0, 2, 'h200, 4, 15, 0, 1, 0, 1, "op2_mult15");
        end
        for (int i = 0; i < 129; i++) begin
            issue(1, 1, 4, 'h200, 4, 1, 0, 1, 0, 1, "wrap");
            issue(0, 1, 4, 'h200, 4, 1, 0, 1, 1, 1, "bubble");
        end
        for (int i = 0; i < 7; i++) begin
            issue(1, 1, 6, 'h200, 4, 1, 0, 1, i == 5, 1, "keyon");
            issue(1, 1, 7, 'h200, 4, 1, 0, 1, 0, 1, "keyon_other");
        end
        issue(1, 0, 20, 'h3ff, 7, 15, 0, 1, 0, 0, "ignored");
        issue(0, 1, 2, 'h200, 4, 1, 0, 1, 0, 1, "alias");

        for (int i = 0; i < 24000; i++) begin
            r = $urandom % 10;
            if (r < 5) begin
                bank = 0; op = 0;
            end else if (r == 9) begin
                bank = $urandom % 2; op = 18 + $urandom % 14;
            end else begin
                bank = $urandom % 2; op = $urandom % 18;
            end
            issue(($urandom % 8) != 0, bank, op, $urandom % 1024, $urandom % 8,
                  $urandom % 16, $urandom % 2, $urandom % 2, ($urandom % 16) == 0,
                  1, "random");
        end

        #3 reset = 1'b1;
        #1 check("async_reset", phase_p2, 10'd0);
        foreach (m_val[i]) m_val[i] = 0;
        m_cnt = 0;
        prev_chk = 0;
        @(posedge clk);
        #1;
        check("reset_hold", phase_p2, 10'd0);
        reset = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int o = 0; o < 18; o++)
                issue(1, b, o, $urandom % 1024, $urandom % 8, $urandom % 16,
                      0, 1, 0, 1, "post_reset");
        issue(0, 0, 31, 0, 0, 0, 0, 0, 0, 0, "flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
